sd_block_responder: RTL and testbench
=====================================

// Module: sd_block_responder
// PURPOSE
//  Target side of the sd_lba/sd_rd/sd_wr/sd_ack block-transfer protocol used by the save-state sequencer.
//  Serves 512-byte blocks from/to an on-chip backing memory, so save slots work without the HPS.
//  Sits between the state-save FSM/system backup RAM (initiator) and a 1-cycle-latency BRAM (backing store).
// PARAMETERS
//  LBA_W    8    low LBA bits used; mem address = {sd_lba[LBA_W-1:0], byte[8:0]}, upper LBA bits ignored
// PORTS
//  clk_sys       in   1        system clock; all logic on rising edge
//  RESET_n       in   1        asynchronous, active-low reset
//  sd_lba        in   32       block number; latched when a request is accepted
//  sd_rd         in   1        initiator wants a block delivered (responder writes initiator buffer)
//  sd_wr         in   1        initiator offers a block (responder reads initiator buffer)
//  sd_ack        out  1        high for the whole transfer of one block
//  sd_buff_addr  out  9        byte index into the initiator buffer
//  sd_buff_dout  out  8        read data to the initiator, valid with sd_buff_wr
//  sd_buff_wr    out  1        one-cycle strobe: write sd_buff_dout at sd_buff_addr
//  sd_buff_din   in   8        initiator buffer data; valid 1 cycle after sd_buff_addr
//  mem_addr      out  LBA_W+9  backing-store address
//  mem_rd        out  1        read strobe; mem_dout valid next cycle
//  mem_dout      in   8        backing-store read data
//  mem_wr        out  1        write strobe for mem_din at mem_addr
//  mem_din       out  8        backing-store write data
//  busy          out  1        high whenever state != IDLE
//  err           out  1        sticky; set on illegal request; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, byte counter 0. Reset mid-block aborts immediately; no resume.
//  States: IDLE -> XFER_RD | XFER_WR -> IDLE.
//  IDLE: level-sensitive. sd_rd^sd_wr at cycle T0 -> latch lba and direction; T1: sd_ack=1, busy=1.
//   sd_rd&sd_wr both high in IDLE: no transfer, no ack, err<=1; re-evaluated each cycle.
//  Requests are sampled only in IDLE; initiator dropping sd_rd/sd_wr after sd_ack rises is normal, ignored.
//  XFER_RD (cycle n = T1+k, k=0..511): mem_rd=1, mem_addr={lba,k}.
//   Cycle T1+k+1: sd_buff_wr=1, sd_buff_addr=k, sd_buff_dout=mem_dout. One byte/clock.
//  XFER_WR: cycle T1+k (k=0..511): sd_buff_addr=k; cycle T1+k+1: mem_wr=1, mem_addr={lba,k}, mem_din=sd_buff_din.
//   sd_buff_addr holds 511 at T1+512.
//  Both directions: last byte at T1+512; T1+513 sd_ack=0, busy=0, state IDLE; new request accepted at T1+513.
//  sd_ack high exactly 513 cycles per block. Byte counter is 10-bit; terminal at 512, never wraps into a 2nd block.
//  mem_rd/mem_wr never both high; sd_buff_wr never high in XFER_WR.
//  LBA above 2^LBA_W-1 aliases (upper bits dropped); not an error.
// CONFIGURATION
//  SD_RESP_WP_EN defined: adds input wp (1 bit). Write accepted while wp=1 (latched at T0) runs the full
//   handshake (513-cycle ack, sd_buff_addr sweep) but mem_wr stays 0 and err<=1. Reads unaffected.
//  SD_RESP_WP_EN undefined: no wp port; every write reaches memory.
// TESTING
//  1 Preload mem block 5 with byte k = k^8'hA5; sd_lba=5,sd_rd=1 -> sd_ack up at T1, 512 sd_buff_wr strobes
//    addr 0..511 data k^A5 at T2..T513, sd_ack low at T514.
//  2 sd_lba=3,sd_wr=1, initiator buffer byte k = k[7:0] -> mem[3*512+k]=k[7:0] for all k; ack 513 cycles.
//  3 sd_rd=sd_wr=1 in IDLE for 4 cycles then sd_wr=0 -> err=1, no ack during overlap; read starts next cycle.
//  4 Replay save-FSM sequence: 64 back-to-back write blocks lba 0..63 then 64 reads -> data round-trips bit-exact.
//  5 RESET_n low at byte 200 of a write -> outputs 0 same edge; mem bytes 0..199 written, 200+ untouched.
//  6 (SD_RESP_WP_EN) wp=1, sd_wr lba 2 -> full 513-cycle ack, zero mem_wr pulses, err=1.

Source files
------------

// File: rtl/sd_block_responder.sv
// Target side of the sd_lba/sd_rd/sd_wr/sd_ack block protocol, backed by a 1-cycle BRAM.
// Optional write-protect input is enabled by defining SD_RESP_WP_EN.
module sd_block_responder #(
  parameter int LBA_W = 8
) (
  input  logic             clk_sys,
  input  logic             RESET_n,
  input  logic [31:0]      sd_lba,
  input  logic             sd_rd,
  input  logic             sd_wr,
  output logic             sd_ack,
  output logic [8:0]       sd_buff_addr,
  output logic [7:0]       sd_buff_dout,
  output logic             sd_buff_wr,
  input  logic [7:0]       sd_buff_din,
  output logic [LBA_W+8:0] mem_addr,
  output logic             mem_rd,
  input  logic [7:0]       mem_dout,
  output logic             mem_wr,
  output logic [7:0]       mem_din,
`ifdef SD_RESP_WP_EN
  input  logic             wp,
`endif
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER_RD = 2'd1,
    XFER_WR = 2'd2
  } state_t;

  state_t           state;
  logic [LBA_W-1:0] lba_q;
  logic [9:0]       cnt;
  logic             wp_q;
  logic             unused_lba;

  // Upper LBA bits alias onto the backing store on purpose.
  assign unused_lba = ^sd_lba[31:LBA_W];

  // Data paths are pass-through so BRAM/buffer latency lines up with
  // the registered strobes; gated so they read 0 outside a strobe.
  assign sd_buff_dout = sd_buff_wr ? mem_dout : 8'd0;
  assign mem_din      = mem_wr ? sd_buff_din : 8'd0;

`ifndef SD_RESP_WP_EN
  assign wp_q = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      state        <= IDLE;
      lba_q        <= '0;
      cnt          <= '0;
      sd_ack       <= 1'b0;
      sd_buff_addr <= '0;
      sd_buff_wr   <= 1'b0;
      mem_addr     <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
`ifdef SD_RESP_WP_EN
      wp_q         <= 1'b0;
`endif
    end else begin
      sd_buff_wr <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (sd_rd && sd_wr) begin
            err <= 1'b1;
          end else if (sd_rd) begin
            state    <= XFER_RD;
            lba_q    <= sd_lba[LBA_W-1:0];
            sd_ack   <= 1'b1;
            busy     <= 1'b1;
            mem_rd   <= 1'b1;
            mem_addr <= {sd_lba[LBA_W-1:0], 9'd0};
          end else if (sd_wr) begin
            state        <= XFER_WR;
            lba_q        <= sd_lba[LBA_W-1:0];
            sd_ack       <= 1'b1;
            busy         <= 1'b1;
            sd_buff_addr <= 9'd0;
`ifdef SD_RESP_WP_EN
            wp_q         <= wp;
            if (wp) err  <= 1'b1;
`endif
          end
        end
        XFER_RD: begin
          if (cnt == 10'd512) begin
            state  <= IDLE;
            cnt    <= '0;
            sd_ack <= 1'b0;
            busy   <= 1'b0;
          end else begin
            cnt          <= cnt + 10'd1;
            sd_buff_wr   <= 1'b1;
            sd_buff_addr <= cnt[8:0];
            if (cnt != 10'd511) begin
              mem_rd   <= 1'b1;
              mem_addr <= {lba_q, cnt[8:0] + 9'd1};
            end
          end
        end
        XFER_WR: begin
          if (cnt == 10'd512) begin
            state  <= IDLE;
            cnt    <= '0;
            sd_ack <= 1'b0;
            busy   <= 1'b0;
          end else begin
            cnt      <= cnt + 10'd1;
            mem_wr   <= !wp_q;
            mem_addr <= {lba_q, cnt[8:0]};
            if (cnt != 10'd511)
              sd_buff_addr <= cnt[8:0] + 9'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_block_responder.sv
// Directed bench for sd_block_responder with BRAM and initiator-buffer models.
// Define SD_RESP_WP_EN to also exercise the write-protect path.
module tb_sd_block_responder;

  logic        clk_sys = 1'b0;
  logic        RESET_n;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic [16:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        busy;
  logic        err;
`ifdef SD_RESP_WP_EN
  logic        wp;
`endif

  logic [7:0] mem [0:131071];
  logic [7:0] ibuf [0:511];
  logic [7:0] obuf [0:511];
  logic [7:0] mem_q = 8'd0;
  logic [7:0] din_q = 8'd0;
  int n_memwr = 0;
  int n_both = 0;
  int n_bwr = 0;
  int total = 0;
  int bad = 0;

  always #5 clk_sys = ~clk_sys;

  sd_block_responder #(.LBA_W(8)) dut (
    .clk_sys(clk_sys),
    .RESET_n(RESET_n),
    .sd_lba(sd_lba),
    .sd_rd(sd_rd),
    .sd_wr(sd_wr),
    .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din),
    .mem_addr(mem_addr),
    .mem_rd(mem_rd),
    .mem_dout(mem_dout),
    .mem_wr(mem_wr),
    .mem_din(mem_din),
`ifdef SD_RESP_WP_EN
    .wp(wp),
`endif
    .busy(busy),
    .err(err)
  );

  assign mem_dout    = mem_q;
  assign sd_buff_din = din_q;

  always @(posedge clk_sys) begin
    if (mem_rd) mem_q <= mem[mem_addr];
    if (mem_wr) begin
      mem[mem_addr] = mem_din;
      n_memwr++;
    end
    if (mem_rd && mem_wr) n_both++;
    din_q <= ibuf[sd_buff_addr];
    if (sd_buff_wr) begin
      obuf[sd_buff_addr] = sd_buff_dout;
      n_bwr++;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] pat(input int b, input int k);
    logic [31:0] v;
    v = k * 7 + b * 29 + (k >> 3);
    return v[7:0] ^ 8'hC3;
  endfunction

  task automatic test_reset();
    logic [47:0] outs;
    RESET_n = 1'b0;
    sd_lba = 32'd0;
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    repeat (3) @(negedge clk_sys);
    outs = {sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr,
            mem_rd, mem_wr, mem_din, busy, err};
    total++;
    if (outs !== 48'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", outs);
    end
    RESET_n = 1'b1;
    @(negedge clk_sys);
    total++;
    if ({sd_ack, busy, err} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle ack/busy/err got=%b want=000", {sd_ack, busy, err});
    end
  endtask

  task automatic test_read_block();
    int e;
    logic [9:0] cc;
    logic [9:0] kk;
    logic [16:0] ea;
    for (int k = 0; k < 512; k++) mem[5*512+k] = 8'(k) ^ 8'hA5;
    sd_lba = 32'd5;
    sd_rd = 1'b1;
    @(negedge clk_sys);
    total++;
    if ({sd_ack, busy} !== 2'b11) begin
      bad++;
      $display("FAIL read_ack_rise got=%b want=11", {sd_ack, busy});
    end
    sd_rd = 1'b0;
    e = 0;
    for (int c = 0; c <= 512; c++) begin
      cc = c[9:0];
      kk = cc - 10'd1;
      ea = {8'd5, cc[8:0]};
      if (sd_ack !== 1'b1 || mem_wr !== 1'b0 || mem_rd !== (c < 512) ||
          (c < 512 && mem_addr !== ea) ||
          (c == 0 && sd_buff_wr !== 1'b0) ||
          (c > 0 && (sd_buff_wr !== 1'b1 || sd_buff_addr !== kk[8:0] ||
                     sd_buff_dout !== (kk[7:0] ^ 8'hA5)))) begin
        if (e == 0)
          $display("FAIL read_stream c=%0d ack=%b mrd=%b maddr=%h bwr=%b baddr=%0d dout=%h want_dout=%h",
                   c, sd_ack, mem_rd, mem_addr, sd_buff_wr, sd_buff_addr, sd_buff_dout,
                   kk[7:0] ^ 8'hA5);
        e++;
      end
      @(negedge clk_sys);
    end
    total++;
    if (e != 0) bad++;
    total++;
    if ({sd_ack, busy, sd_buff_wr} !== 3'b000) begin
      bad++;
      $display("FAIL read_end ack/busy/bwr got=%b want=000", {sd_ack, busy, sd_buff_wr});
    end
    e = 0;
    for (int k = 0; k < 512; k++)
      if (obuf[k] !== (8'(k) ^ 8'hA5)) e++;
    total++;
    if (e != 0) begin
      bad++;
      $display("FAIL read_buffer bad_bytes=%0d want=0", e);
    end
  endtask

  task automatic test_write_block();
    int e;
    int w0;
    int b0;
    logic [9:0] cc;
    logic [9:0] kk;
    logic [16:0] ea;
    logic [8:0] eb;
    for (int k = 0; k < 512; k++) begin
      ibuf[k] = 8'(k);
      mem[3*512+k] = 8'hFF;
    end
    w0 = n_memwr;
    b0 = n_bwr;
    sd_lba = 32'd3;
    sd_wr = 1'b1;
    @(negedge clk_sys);
    sd_wr = 1'b0;
    e = 0;
    for (int c = 0; c <= 512; c++) begin
      cc = c[9:0];
      kk = cc - 10'd1;
      ea = {8'd3, kk[8:0]};
      eb = (c > 511) ? 9'd511 : cc[8:0];
      if (sd_ack !== 1'b1 || busy !== 1'b1 || sd_buff_wr !== 1'b0 ||
          mem_rd !== 1'b0 || sd_buff_addr !== eb || mem_wr !== (c > 0) ||
          (c > 0 && (mem_addr !== ea || mem_din !== kk[7:0]))) begin
        if (e == 0)
          $display("FAIL write_stream c=%0d ack=%b baddr=%0d want=%0d mwr=%b maddr=%h want=%h din=%h",
                   c, sd_ack, sd_buff_addr, eb, mem_wr, mem_addr, ea, mem_din);
        e++;
      end
      @(negedge clk_sys);
    end
    total++;
    if (e != 0) bad++;
    total++;
    if ({sd_ack, busy} !== 2'b00) begin
      bad++;
      $display("FAIL write_end ack/busy got=%b want=00", {sd_ack, busy});
    end
    e = 0;
    for (int k = 0; k < 512; k++)
      if (mem[3*512+k] !== 8'(k)) e++;
    total++;
    if (e != 0) begin
      bad++;
      $display("FAIL write_mem bad_bytes=%0d want=0", e);
    end
    total++;
    if (n_memwr - w0 != 512 || n_bwr - b0 != 0) begin
      bad++;
      $display("FAIL write_strobes mem_wr=%0d want=512 buff_wr=%0d want=0",
               n_memwr - w0, n_bwr - b0);
    end
  endtask

  task automatic test_illegal();
    int e;
    int n;
    sd_lba = 32'd5;
    sd_rd = 1'b1;
    sd_wr = 1'b1;
    e = 0;
    repeat (4) begin
      @(negedge clk_sys);
      if (sd_ack !== 1'b0 || busy !== 1'b0 || err !== 1'b1) e++;
    end
    total++;
    if (e != 0) begin
      bad++;
      $display("FAIL illegal_overlap bad_cycles=%0d ack=%b err=%b want ack=0 err=1", e, sd_ack, err);
    end
    sd_wr = 1'b0;
    @(negedge clk_sys);
    total++;
    if (sd_ack !== 1'b1) begin
      bad++;
      $display("FAIL illegal_then_read ack=%b want=1", sd_ack);
    end
    sd_rd = 1'b0;
    n = 0;
    while (sd_ack === 1'b1 && n < 600) begin
      n++;
      @(negedge clk_sys);
    end
    total++;
    if (n != 513 || err !== 1'b1) begin
      bad++;
      $display("FAIL illegal_sticky ack_cycles=%0d want=513 err=%b want=1", n, err);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int ack_bad;
    int data_bad;
    int b0;
    ack_bad = 0;
    data_bad = 0;
    b0 = n_both;
    for (int b = 0; b < 64; b++) begin
      for (int k = 0; k < 512; k++) ibuf[k] = pat(b, k);
      sd_lba = b;
      sd_wr = 1'b1;
      @(negedge clk_sys);
      sd_wr = 1'b0;
      n = 0;
      while (sd_ack === 1'b1 && n < 600) begin
        n++;
        @(negedge clk_sys);
      end
      if (n != 513) ack_bad++;
    end
    for (int b = 0; b < 64; b++) begin
      sd_lba = b;
      sd_rd = 1'b1;
      @(negedge clk_sys);
      sd_rd = 1'b0;
      n = 0;
      while (sd_ack === 1'b1 && n < 600) begin
        n++;
        @(negedge clk_sys);
      end
      if (n != 513) ack_bad++;
      for (int k = 0; k < 512; k++)
        if (obuf[k] !== pat(b, k)) data_bad++;
    end
    total++;
    if (ack_bad != 0) begin
      bad++;
      $display("FAIL b2b_ack_len bad_blocks=%0d want=0", ack_bad);
    end
    total++;
    if (data_bad != 0) begin
      bad++;
      $display("FAIL b2b_roundtrip bad_bytes=%0d want=0", data_bad);
    end
    total++;
    if (n_both != b0) begin
      bad++;
      $display("FAIL b2b_rd_wr_overlap cycles=%0d want=0", n_both - b0);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [47:0] outs;
    int e;
    int w0;
    for (int k = 0; k < 512; k++) begin
      ibuf[k] = 8'(k) ^ 8'h3C;
      mem[7*512+k] = 8'hEE;
    end
    sd_lba = 32'd7;
    sd_wr = 1'b1;
    @(negedge clk_sys);
    sd_wr = 1'b0;
    repeat (201) @(negedge clk_sys);
    total++;
    if (mem_wr !== 1'b1 || mem_addr !== {8'd7, 9'd200}) begin
      bad++;
      $display("FAIL midreset_position mwr=%b maddr=%h want 1/%h", mem_wr, mem_addr, {8'd7, 9'd200});
    end
    RESET_n = 1'b0;
    #1;
    outs = {sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr,
            mem_rd, mem_wr, mem_din, busy, err};
    total++;
    if (outs !== 48'd0) begin
      bad++;
      $display("FAIL midreset_outputs got=%h want=0", outs);
    end
    w0 = n_memwr;
    @(negedge clk_sys);
    RESET_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    e = 0;
    for (int k = 0; k < 512; k++)
      if (mem[7*512+k] !== ((k < 200) ? (8'(k) ^ 8'h3C) : 8'hEE)) e++;
    total++;
    if (e != 0 || n_memwr != w0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_mem bad_bytes=%0d extra_wr=%0d busy=%b want 0/0/0",
               e, n_memwr - w0, busy);
    end
  endtask

  task automatic test_alias();
    int n;
    int e;
    sd_lba = 32'hABCD_0105;
    sd_rd = 1'b1;
    @(negedge clk_sys);
    sd_rd = 1'b0;
    n = 0;
    while (sd_ack === 1'b1 && n < 600) begin
      n++;
      @(negedge clk_sys);
    end
    e = 0;
    for (int k = 0; k < 512; k++)
      if (obuf[k] !== pat(5, k)) e++;
    total++;
    if (n != 513 || e != 0 || err !== 1'b0) begin
      bad++;
      $display("FAIL lba_alias ack_cycles=%0d want=513 bad_bytes=%0d err=%b want=0", n, e, err);
    end
  endtask

`ifdef SD_RESP_WP_EN
  task automatic test_write_protect();
    int n;
    int e;
    int w0;
    for (int k = 0; k < 512; k++) begin
      ibuf[k] = 8'h00;
      mem[2*512+k] = 8'h5A;
    end
    w0 = n_memwr;
    wp = 1'b1;
    sd_lba = 32'd2;
    sd_wr = 1'b1;
    @(negedge clk_sys);
    sd_wr = 1'b0;
    wp = 1'b0;
    n = 0;
    while (sd_ack === 1'b1 && n < 600) begin
      n++;
      @(negedge clk_sys);
    end
    e = 0;
    for (int k = 0; k < 512; k++)
      if (mem[2*512+k] !== 8'h5A) e++;
    total++;
    if (n != 513 || n_memwr != w0 || err !== 1'b1 || e != 0) begin
      bad++;
      $display("FAIL write_protect ack=%0d/513 mem_wr=%0d/0 err=%b/1 changed=%0d/0",
               n, n_memwr - w0, err, e);
    end
  endtask
`endif

  initial begin
`ifdef SD_RESP_WP_EN
    wp = 1'b0;
`endif
    test_reset();
    test_read_block();
    test_write_block();
    test_illegal();
    test_back_to_back();
    test_reset_mid_write();
    test_alias();
`ifdef SD_RESP_WP_EN
    test_write_protect();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
